lfsr_req_gen: RTL and testbench

- Stimulus stage directly downstream of the testbench LFSR driver.
- Pulses the LFSR enable, captures the random words it returns, and turns them into DDR read/write requests.
- Buffers requests in a small FIFO and presents them on a valid/ready interface to the controller front end.
- Issues exactly NUM_REQ requests per start, then signals done.

---
 rtl/lfsr_req_gen.sv | 171 +++++++++++++++++
 tb/tb_lfsr_req_gen.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_req_gen.sv
// LFSR-driven DDR request generator: fetches random words, decodes them into read/write
// requests, buffers them in a FIFO. Optional readback-after-write: LFSR_REQ_GEN_READBACK_EN.
module lfsr_req_gen #(
   parameter int RAND_W     = 32,
   parameter int ADDR_W     = 28,
   parameter int DATA_W     = 64,
   parameter int NUM_REQ    = 256,
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_ALIGN = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              lfsr_en,
   input  logic              lfsr_valid,
   input  logic [RAND_W-1:0] lfsr_random,
   output logic              req_valid,
   input  logic              req_ready,
   output logic              req_write,
   output logic [ADDR_W-1:0] req_addr,
   output logic [DATA_W-1:0] req_wdata,
   output logic              busy,
   output logic              done,
   output logic [15:0]       issued_cnt,
   output logic [2:0]        dbg_state
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      WAIT  = 3'd2,
      PUSH  = 3'd3,
      DRAIN = 3'd4
   } state_t;

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int ENT_W = 1 + ADDR_W + DATA_W;
   localparam logic [16:0]       NUM_REQ_L  = 17'(NUM_REQ);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'({ADDR_W{1'b1}} << ADDR_ALIGN);
   localparam logic [PTR_W:0]    DEPTH_L    = (PTR_W+1)'(FIFO_DEPTH);

   state_t state, state_nxt;

   logic [1:0]        widx;
   logic              cur_write;
   logic [ADDR_W-1:0] cur_addr;
   logic [RAND_W-1:0] cur_w1, cur_w2;
   logic [15:0]       gen_cnt;
   logic              rb_pend;
   logic              rb_start;
   logic              gen_last;

   logic [ENT_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   count;
   logic             push, pop, full, ent_write;
   logic [ENT_W-1:0] push_ent;

   // Handshake: a request transfers on any cycle where req_valid && req_ready; while
   // req_valid is high and req_ready low the head entry and its fields stay unchanged.
   assign pop       = req_valid && req_ready;
   assign full      = (count == DEPTH_L);
   assign push      = (state == PUSH) && (!full || pop);
   assign gen_last  = ({1'b0, gen_cnt} + 17'd1) >= NUM_REQ_L;
   assign ent_write = cur_write && !rb_pend;
   assign push_ent  = {ent_write, cur_addr, ent_write ? {cur_w2, cur_w1} : {DATA_W{1'b0}}};

`ifdef LFSR_REQ_GEN_READBACK_EN
   assign rb_start = cur_write && !rb_pend;
`else
   assign rb_start = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start) state_nxt = FETCH;
         FETCH: state_nxt = WAIT;
         WAIT: begin
            if (lfsr_valid) begin
               if (widx == 2'd2 || (widx == 2'd0 && !lfsr_random[RAND_W-1])) state_nxt = PUSH;
               else                                                         state_nxt = FETCH;
            end
         end
         PUSH: begin
            if (push) begin
               if (gen_last)      state_nxt = DRAIN;
               else if (rb_start) state_nxt = PUSH;
               else               state_nxt = FETCH;
            end
         end
         DRAIN: if (count == '0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         widx       <= 2'd0;
         cur_write  <= 1'b0;
         cur_addr   <= '0;
         cur_w1     <= '0;
         cur_w2     <= '0;
         gen_cnt    <= '0;
         issued_cnt <= '0;
         rb_pend    <= 1'b0;
      end else begin
         if (state == IDLE && start) begin
            gen_cnt    <= '0;
            issued_cnt <= '0;
         end else if (pop) begin
            issued_cnt <= issued_cnt + 16'd1;
         end
         if (push) begin
            gen_cnt <= gen_cnt + 16'd1;
            rb_pend <= rb_start && !gen_last;
         end
         // Word 0 carries type and address; writes pull two more words for data.
         if (state == WAIT && lfsr_valid) begin
            case (widx)
               2'd0: begin
                  cur_write <= lfsr_random[RAND_W-1];
                  cur_addr  <= lfsr_random[ADDR_W-1:0] & ALIGN_MASK;
                  widx      <= lfsr_random[RAND_W-1] ? 2'd1 : 2'd0;
               end
               2'd1: begin
                  cur_w1 <= lfsr_random;
                  widx   <= 2'd2;
               end
               default: begin
                  cur_w2 <= lfsr_random;
                  widx   <= 2'd0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_ent;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign req_valid = (count != '0);
   assign {req_write, req_addr, req_wdata} = req_valid ? mem[rd_ptr] : {ENT_W{1'b0}};
   assign lfsr_en   = (state == FETCH);
   assign busy      = (state != IDLE);
   assign done      = (state == DRAIN) && (count == '0);
   assign dbg_state = state;

endmodule

// File: tb/tb_lfsr_req_gen.sv
// Bench for lfsr_req_gen: vector table, back-pressure, stray valid, mid-run reset and
// randomized runs checked against a word-stream decode model.
module tb_lfsr_req_gen;

   localparam int RAND_W     = 32;
   localparam int ADDR_W     = 28;
   localparam int DATA_W     = 64;
   localparam int NUM_REQ    = 8;
   localparam int FIFO_DEPTH = 4;
   localparam int ADDR_ALIGN = 6;
   localparam int REQ_W      = 1 + ADDR_W + DATA_W;
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_PUSH = 3'd3;

   logic              clk, rst_n, start;
   logic              lfsr_en, lfsr_valid;
   logic [RAND_W-1:0] lfsr_random;
   logic              req_valid, req_ready, req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              busy, done;
   logic [15:0]       issued_cnt;
   logic [2:0]        dbg_state;

   lfsr_req_gen #(
      .RAND_W(RAND_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
      .NUM_REQ(NUM_REQ), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_ALIGN(ADDR_ALIGN)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .lfsr_en(lfsr_en), .lfsr_valid(lfsr_valid), .lfsr_random(lfsr_random),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .busy(busy), .done(done), .issued_cnt(issued_cnt), .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [31:0]      src_q[$];
   logic [31:0]      word_log[$];
   logic [REQ_W-1:0] exp_q[$];
   logic [REQ_W-1:0] act_q[$];
   int  rand_mode  = 0;
   bit  ready_rand = 1'b0;
   bit  stray      = 1'b0;
   int  en_pulses  = 0;
   int  done_cnt   = 0;
   int  runs_done  = 0;

   typedef struct {
      logic [31:0] w0, w1, w2;
      logic        wr;
      logic [27:0] addr;
      logic [63:0] wdata;
      int          lat;
   } vec_t;
   vec_t vecs[5];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // LFSR driver: answers each enable with one word on the following cycle; also drives
   // randomized ready and stray valids on request.
   initial begin
      logic [31:0] w;
      bit en_prev;
      en_prev     = 1'b0;
      lfsr_valid  = 1'b0;
      lfsr_random = '0;
      forever begin
         @(posedge clk);
         #1;
         lfsr_valid = 1'b0;
         if (!rst_n) en_prev = 1'b0;
         if (en_prev) begin
            if (src_q.size() > 0) w = src_q.pop_front();
            else if (rand_mode == 1) w = $urandom & 32'h7FFF_FFFF;
            else w = $urandom;
            lfsr_valid  = 1'b1;
            lfsr_random = w;
            word_log.push_back(w);
         end else if (stray) begin
            lfsr_valid  = 1'b1;
            lfsr_random = $urandom;
         end
         if (ready_rand) req_ready = 1'($urandom_range(0, 1));
         en_prev = lfsr_en;
         if (lfsr_en) en_pulses++;
      end
   end

   // monitor: handshake capture, hold-stability and done counting
   initial begin
      bit hold_prev;
      logic [REQ_W-1:0] prev_out;
      hold_prev = 1'b0;
      prev_out  = '0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (hold_prev) begin
               check("hold_valid", req_valid, 1'b1);
               check("hold_stable", {req_write, req_addr, req_wdata}, prev_out);
            end
            if (req_valid && req_ready) act_q.push_back({req_write, req_addr, req_wdata});
            hold_prev = req_valid && !req_ready;
            prev_out  = {req_write, req_addr, req_wdata};
            if (done) done_cnt++;
         end else begin
            hold_prev = 1'b0;
         end
      end
   end

   // reference model: decode the delivered word stream into the expected request list
   task automatic build_exp(output int used);
      int idx, n;
      longint a;
      logic [ADDR_W-1:0] addr;
      idx = 0;
      n   = 0;
      exp_q.delete();
      while (n < NUM_REQ && idx < word_log.size()) begin
         a    = longint'(word_log[idx]) % (longint'(1) << ADDR_W);
         a    = (a / (longint'(1) << ADDR_ALIGN)) * (longint'(1) << ADDR_ALIGN);
         addr = a[ADDR_W-1:0];
         if (word_log[idx] >= 32'h8000_0000) begin
            if (idx + 3 > word_log.size()) break;
            exp_q.push_back({1'b1, addr, word_log[idx+2], word_log[idx+1]});
            idx += 3;
            n++;
`ifdef LFSR_REQ_GEN_READBACK_EN
            if (n < NUM_REQ) begin
               exp_q.push_back({1'b0, addr, 64'h0});
               n++;
            end
`endif
         end else begin
            exp_q.push_back({1'b0, addr, 64'h0});
            idx++;
            n++;
         end
      end
      used = idx;
   endtask

   task automatic check_run(input string tag);
      int used;
      build_exp(used);
      check({tag, "_words_used"}, word_log.size(), used);
      check({tag, "_req_count"}, act_q.size(), exp_q.size());
      for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
         check({tag, "_req"}, act_q[i], exp_q[i]);
      act_q.delete();
      exp_q.delete();
      word_log.delete();
   endtask

   task automatic set_ready(input bit r, input bit rnd);
      @(posedge clk);
      #2;
      ready_rand = rnd;
      req_ready  = r;
   endtask

   task automatic do_start(input string tag);
      @(negedge clk);
      check({tag, "_busy_before"}, busy, 1'b0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy_after"}, busy, 1'b1);
   endtask

   task automatic wait_done(input string tag);
      int t;
      t = 0;
      while (!done && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_done_seen"}, done, 1'b1);
      if (done) begin
         runs_done++;
         check({tag, "_issued_at_done"}, issued_cnt, 16'(NUM_REQ));
         check({tag, "_busy_at_done"}, busy, 1'b1);
         check({tag, "_fifo_empty_at_done"}, req_valid, 1'b0);
         @(negedge clk);
         check({tag, "_done_one_cycle"}, done, 1'b0);
         check({tag, "_busy_after_done"}, busy, 1'b0);
         check({tag, "_issued_hold"}, issued_cnt, 16'(NUM_REQ));
      end
   endtask

   initial begin
      int lat, snap, dc0;
      vecs[0] = '{w0: 32'h0123_4567, w1: 32'h0, w2: 32'h0, wr: 1'b0,
                  addr: 28'h123_4540, wdata: 64'h0, lat: 3};
      vecs[1] = '{w0: 32'h8ABC_DEFF, w1: 32'h1111_1111, w2: 32'h2222_2222, wr: 1'b1,
                  addr: 28'hABC_DEC0, wdata: 64'h2222_2222_1111_1111, lat: 7};
      vecs[2] = '{w0: 32'h7FFF_FFFF, w1: 32'h0, w2: 32'h0, wr: 1'b0,
                  addr: 28'hFFF_FFC0, wdata: 64'h0, lat: 3};
      vecs[3] = '{w0: 32'hF000_003F, w1: 32'hDEAD_BEEF, w2: 32'hCAFE_F00D, wr: 1'b1,
                  addr: 28'h000_0000, wdata: 64'hCAFE_F00D_DEAD_BEEF, lat: 7};
      vecs[4] = '{w0: 32'h0000_0000, w1: 32'h0, w2: 32'h0, wr: 1'b0,
                  addr: 28'h000_0000, wdata: 64'h0, lat: 3};

      rst_n     = 1'b0;
      start     = 1'b0;
      req_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_valid", req_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_lfsr_en", lfsr_en, 1'b0);
      check("rst_issued", issued_cnt, 16'd0);
      check("rst_outputs", {req_write, req_addr, req_wdata}, '0);
      check("rst_state", dbg_state, ST_IDLE);
      @(negedge clk);
      rst_n = 1'b1;

      // stray valid while idle
      stray = 1'b1;
      repeat (4) @(negedge clk);
      stray = 1'b0;
      check("stray_idle_req_valid", req_valid, 1'b0);
      check("stray_idle_busy", busy, 1'b0);
      check("stray_idle_state", dbg_state, ST_IDLE);

      // vector table: first request decoded from known words, rest random
      set_ready(1'b1, 1'b1);
      for (int v = 0; v < 5; v++) begin
         rand_mode = 0;
         src_q.delete();
         src_q.push_back(vecs[v].w0);
         if (vecs[v].wr) begin
            src_q.push_back(vecs[v].w1);
            src_q.push_back(vecs[v].w2);
         end
         do_start("vec");
         lat = 0;
         while (!req_valid && lat < 50) begin
            @(negedge clk);
            lat++;
         end
         check("vec_latency", lat, vecs[v].lat);
         wait_done("vec");
         if (act_q.size() > 0)
            check("vec_first_req", act_q[0], {vecs[v].wr, vecs[v].addr, vecs[v].wdata});
         else
            check("vec_first_req_present", act_q.size(), 1);
         check_run("vec");
      end

      // back-pressure: stall in PUSH with a full FIFO, stray valids ignored
      set_ready(1'b0, 1'b0);
      rand_mode = 1;
      @(negedge clk);
      en_pulses = 0;
      do_start("bp");
      repeat (40) @(negedge clk);
      check("bp_en_pulses", en_pulses, FIFO_DEPTH + 1);
      check("bp_state_push", dbg_state, ST_PUSH);
      check("bp_req_valid", req_valid, 1'b1);
      check("bp_issued_zero", issued_cnt, 16'd0);
      snap  = en_pulses;
      stray = 1'b1;
      repeat (10) @(negedge clk);
      stray = 1'b0;
      check("bp_no_more_en", en_pulses, snap);
      check("bp_still_push", dbg_state, ST_PUSH);
      set_ready(1'b1, 1'b0);
      wait_done("bp");
      check_run("bp");

      // reset mid-run with two entries queued
      set_ready(1'b0, 1'b0);
      rand_mode = 1;
      do_start("rst");
      repeat (6) @(negedge clk);
      check("mid_two_queued", req_valid, 1'b1);
      dc0 = done_cnt;
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_req_valid", req_valid, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_lfsr_en", lfsr_en, 1'b0);
      check("mid_rst_issued", issued_cnt, 16'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("mid_rst_no_done", done_cnt, dc0);
      check("mid_rst_idle", dbg_state, ST_IDLE);
      act_q.delete();
      word_log.delete();
      src_q.delete();
      set_ready(1'b1, 1'b1);
      do_start("post_rst");
      wait_done("post_rst");
      check_run("post_rst");

      // randomized runs with a stray start mid-run
      for (int r = 0; r < 4; r++) begin
         rand_mode = 0;
         do_start("rnd");
         repeat ($urandom_range(2, 20)) @(negedge clk);
         if (busy) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
         wait_done("rnd");
         check_run("rnd");
      end

      check("done_pulse_total", done_cnt, runs_done);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
